// File: rtl/demux8_rr_scheduler.sv
// Round-robin scheduler for the 8-way demux datapath: routes one upstream
// valid/ready stream to one enabled destination at a time, in fixed-length bursts.
module demux8_rr_scheduler #(
  parameter int DATA_W    = 1,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        chan_en,
  input  logic [7:0]        dst_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [2:0]        sel,
  output logic [DATA_W-1:0] dout,
  output logic [7:0]        dvalid,
  output logic              busy
);

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);
  localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_XFER   = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [2:0]          ptr_r, ptr_nxt_s;
  logic [2:0]          sel_r, sel_nxt_s;
  logic [7:0]          beat_cnt_r, beat_cnt_nxt_s;
  logic [7:0]          stall_cnt_r, stall_cnt_nxt_s;
  logic [DATA_W-1:0]   dout_r, dout_nxt_s;
  logic [7:0]          dvalid_r, dvalid_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                in_ready_s;
  logic [3:0]          pick_s;

  // First enabled destination after ptr (ptr itself last); bit 3 flags a hit.
  function automatic logic [3:0] rr_pick(input logic [7:0] en, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr + 3'(k);
      if (en[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign pick_s     = rr_pick(chan_en, ptr_r);
  assign in_ready_s = (state_r == ST_XFER) & chan_en[sel_r] & dst_ready[sel_r];

  // Next-state, counter and output-register computation.
  always_comb begin
    state_nxt_s     = state_r;
    ptr_nxt_s       = ptr_r;
    sel_nxt_s       = sel_r;
    beat_cnt_nxt_s  = beat_cnt_r;
    stall_cnt_nxt_s = stall_cnt_r;
    dout_nxt_s      = dout_r;
    dvalid_nxt_s    = 8'd0;
    case (state_r)
      ST_IDLE: begin
        if (chan_en != 8'd0) begin
          state_nxt_s = ST_SEARCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (pick_s[3]) begin
          sel_nxt_s       = pick_s[2:0];
          beat_cnt_nxt_s  = 8'd0;
          stall_cnt_nxt_s = 8'd0;
          state_nxt_s     = ST_XFER;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (!chan_en[sel_r]) begin
          ptr_nxt_s   = sel_r;
          state_nxt_s = ST_SEARCH;
        end else if (!dst_ready[sel_r]) begin
          // Destination stalled: skip it once the limit is hit.
          if (stall_cnt_r == STALL_LAST) begin
            ptr_nxt_s   = sel_r;
            state_nxt_s = ST_SEARCH;
          end else begin
            stall_cnt_nxt_s = stall_cnt_r + 8'd1;
          end
        end else begin
          stall_cnt_nxt_s = 8'd0;
          if (in_valid) begin
            beat_cnt_nxt_s = beat_cnt_r + 8'd1;
            dvalid_nxt_s   = 8'd1 << sel_r;
            dout_nxt_s     = in_data;
            if (beat_cnt_r == BURST_LAST) begin
              ptr_nxt_s   = sel_r;
              state_nxt_s = ST_SEARCH;
            end else begin
              state_nxt_s = ST_XFER;
            end
          end else begin
            state_nxt_s = ST_XFER;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 3'd7;
      sel_r       <= 3'd0;
      beat_cnt_r  <= 8'd0;
      stall_cnt_r <= 8'd0;
      dout_r      <= '0;
      dvalid_r    <= 8'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      sel_r       <= sel_nxt_s;
      beat_cnt_r  <= beat_cnt_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      dout_r      <= dout_nxt_s;
      dvalid_r    <= dvalid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign in_ready = in_ready_s;
  assign sel      = sel_r;
  assign dout     = dout_r;
  assign dvalid   = dvalid_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_demux8_rr_scheduler.sv
// Scoreboard bench for demux8_rr_scheduler: a behavioural model predicts every
// accepted word; a monitor matches the registered strobes against the queue.
module tb_demux8_rr_scheduler;

  localparam int DATA_W    = 1;
  localparam int BURST     = 4;
  localparam int STALL_MAX = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        chan_en = 8'd0;
  logic [7:0]        dst_ready = 8'd0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [2:0]        sel;
  logic [DATA_W-1:0] dout;
  logic [7:0]        dvalid;
  logic              busy;

  demux8_rr_scheduler #(.DATA_W(DATA_W), .BURST(BURST), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .chan_en(chan_en), .dst_ready(dst_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .sel(sel),
    .dout(dout), .dvalid(dvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                c;
    logic [7:0]        dv;
    logic [DATA_W-1:0] d;
  } exp_t;
  exp_t sbq[$];

  // Model: mode 0 = idle, 1 = choosing next destination, 2 = sending a burst.
  int m_mode, m_ptr, m_sel, m_beats, m_stalls;
  logic [DATA_W-1:0] m_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit m_ready();
    return (m_mode == 2) && chan_en[m_sel] && dst_ready[m_sel];
  endfunction

  task automatic m_reset();
    m_mode = 0; m_ptr = 7; m_sel = 0; m_beats = 0; m_stalls = 0;
  endtask

  task automatic m_update();
    case (m_mode)
      0: if (chan_en != 8'd0) m_mode = 1;
      1: begin
        if (chan_en == 8'd0) m_mode = 0;
        else begin
          for (int k = 1; k <= 8; k++) begin
            if (m_mode == 1 && chan_en[(m_ptr + k) % 8]) begin
              m_sel = (m_ptr + k) % 8; m_beats = 0; m_stalls = 0; m_mode = 2;
            end
          end
        end
      end
      2: begin
        if (!chan_en[m_sel]) begin
          m_ptr = m_sel; m_mode = 1;
        end else if (!dst_ready[m_sel]) begin
          m_stalls++;
          if (m_stalls == STALL_MAX) begin m_ptr = m_sel; m_mode = 1; end
        end else begin
          m_stalls = 0;
          if (in_valid) begin
            m_beats++;
            if (m_beats == BURST) begin m_ptr = m_sel; m_mode = 1; end
          end
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  // One clock: check combinational/registered state, log acceptance, advance model.
  task automatic cycle();
    exp_t e;
    in_data = DATA_W'($urandom);
    @(negedge clk);
    #1;
    check("in_ready", in_ready, m_ready());
    check("sel", sel, m_sel);
    check("busy", busy, m_mode != 0);
    if (in_valid && m_ready()) begin
      e.c = cyc; e.dv = 8'(1 << m_sel); e.d = in_data;
      sbq.push_back(e);
    end
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_dvalid", dvalid, 8'd0);
    check("rst_sel", sel, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    sbq.delete();
    m_reset();
    m_last = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_xfer(input int s, input int b, input string name);
    int g = 0;
    while (!(m_mode == 2 && m_sel == s && m_beats == b) && g < 200) begin
      cycle();
      g++;
    end
    check(name, (m_mode == 2 && m_sel == s && m_beats == b), 1'b1);
  endtask

  // Monitor: every strobe must match the oldest accepted word, one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dvalid != 8'd0) begin
        if (sbq.size() == 0) begin
          check("unexpected_strobe", dvalid, 8'd0);
        end else begin
          e = sbq.pop_front();
          check("dvalid", dvalid, e.dv);
          check("dout", dout, e.d);
          check("latency", cyc, e.c + 1);
          m_last = e.d;
        end
      end else begin
        check("dout_hold", dout, m_last);
        if (sbq.size() != 0 && sbq[0].c + 1 <= cyc) begin
          check("missing_strobe", dvalid, sbq[0].dv);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    m_reset();
    do_reset();

    chan_en = 8'hFF; dst_ready = 8'hFF; in_valid = 1'b1;
    repeat (90) cycle();

    do_reset();
    chan_en = 8'b1010_0100;
    repeat (60) cycle();

    do_reset();
    chan_en = 8'hFF; dst_ready = 8'hFF;
    wait_xfer(0, 2, "reach_bp");
    dst_ready[0] = 1'b0;
    repeat (5) cycle();
    dst_ready[0] = 1'b1;
    repeat (20) cycle();

    do_reset();
    chan_en = 8'h0C; dst_ready = 8'hF7;
    repeat (120) cycle();

    do_reset();
    chan_en = 8'hFF; dst_ready = 8'hFF;
    wait_xfer(1, 2, "reach_disable");
    chan_en[1] = 1'b0;
    repeat (20) cycle();
    chan_en = 8'h00;
    repeat (10) cycle();
    check("idle_busy", busy, 1'b0);

    do_reset();
    chan_en = 8'($urandom); dst_ready = 8'hFF;
    repeat (800) begin
      if ($urandom_range(0, 15) == 0) chan_en = 8'($urandom);
      if ($urandom_range(0, 3) == 0) dst_ready = 8'($urandom | $urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end

    do_reset();
    chan_en = 8'hFF; dst_ready = 8'hFF; in_valid = 1'b1;
    wait_xfer(5, 1, "reach_sel5");
    do_reset();
    repeat (12) cycle();

    in_valid = 1'b0;
    repeat (4) cycle();
    check("queue_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux8_rr_scheduler.md
Name: demux8_rr_scheduler

Overview:
- Round-robin scheduler and sequencer for the 8-way 1-to-8 demultiplexer datapath.
- Accepts a single upstream valid/ready stream and grants it to one of 8 destinations at a time, in bursts of BURST beats.
- Drives the demux select and data, plus a registered one-hot strobe per destination.
- Skips disabled destinations and abandons a destination that stalls too long.

Parameters:
- DATA_W, 1, width of the routed data word (1 matches the demux single-bit input).
- BURST, 4, beats sent to one destination before rotating (legal 1..256).
- STALL_MAX, 16, consecutive cycles with the selected destination not ready before it is skipped (legal 1..256).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- chan_en  in  8  per-destination enable mask; bit i enables destination i.
- dst_ready  in  8  per-destination ready (backpressure).
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  upstream word accepted when in_valid & in_ready.
- sel  out  3  demux select (s2 s1 s0 = sel[2:0]); current destination.
- dout  out  DATA_W  demux data input, registered.
- dvalid  out  8  one-hot strobe marking the destination of dout this cycle.
- busy  out  1  high in SEARCH or XFER.

Behaviour:
- Reset values (async on rst_n low): state=IDLE, sel=0, ptr=7, beat_cnt=0, stall_cnt=0, dout=0, dvalid=0, busy=0.
- in_ready is combinational: high only in XFER with chan_en[sel] & dst_ready[sel].
- IDLE:
  - in_ready=0.
  - If chan_en!=0, go to SEARCH next cycle.
- SEARCH (exactly 1 cycle):
  - Pick the first i with chan_en[i]=1, scanning ptr+1, ptr+2, ... mod 8; the scan includes ptr itself last.
  - Load sel<=i, beat_cnt<=0, stall_cnt<=0, then go to XFER.
  - If chan_en==0, go to IDLE and leave sel unchanged.
  - dst_ready is not considered in the scan.
- XFER:
  - Transfer = in_valid & in_ready.
  - On a transfer: next cycle dout=in_data and dvalid=(1<<sel), i.e. 1-cycle latency, strobe for exactly 1 cycle. beat_cnt increments and stall_cnt clears.
  - If no transfer occurs, dvalid=0 next cycle and dout holds its last value.
  - Transfer with beat_cnt==BURST-1: ptr<=sel, go to SEARCH.
  - chan_en[sel]==0 (disabled mid-burst): no transfer that cycle; ptr<=sel, go to SEARCH next cycle. Beats already delivered stand.
  - dst_ready[sel]==0 with chan_en[sel]=1: stall_cnt increments.
    - When stall_cnt reaches STALL_MAX-1 with ready still low: ptr<=sel, go to SEARCH (destination skipped).
    - Any cycle with dst_ready[sel]=1 clears stall_cnt, even if in_valid is low.
  - in_valid low with dst_ready[sel] high: stay in XFER indefinitely; upstream idleness is never a timeout.
- sel changes only on SEARCH exit, so the demux select is stable for a whole burst.
- Simultaneous events:
  - chan_en[sel] falling on the same cycle as the final beat: the transfer is blocked (in_ready=0), so the burst ends via the disable path.
  - Both the stall limit and the disable occurring together: the disable path is taken; the result is the same.
- Only one destination is selected at any time; dvalid is never multi-hot.
- rst_n low mid-burst: all state returns to reset values immediately. dvalid drops asynchronously, and no partial strobe is produced after release.
- Counter widths: beat_cnt and stall_cnt are each 8 bits and compare against parameter-1.

Test Plan:
- Reset and idle: chan_en=8'hFF, dst_ready=8'hFF, in_valid=1 continuously, BURST=4.
  - First burst goes to sel=0: 4 dvalid=8'h01 strobes, each 1 cycle after acceptance.
  - Then one SEARCH cycle, then sel=1 with dvalid=8'h02, and so on.
  - Wraps from 7 back to 0.
- Mask skipping: chan_en=8'b1010_0100, starting from reset. Bursts go to sel 2, 5, 7, 2, ... and no dvalid bit outside the mask ever asserts.
- Backpressure: dst_ready[0]=0 for 5 cycles mid-burst (STALL_MAX=16).
  - in_ready=0 during the stall and no dvalid strobes.
  - The burst then completes its remaining beats on sel=0.
- Stall timeout: dst_ready[3]=0 permanently, chan_en=8'h0C.
  - After 16 stalled cycles on sel=3, the block moves to sel=2, then returns to 3 and stalls again.
  - sel=2 still receives full 4-beat bursts.
- Disable mid-burst: clear chan_en[1] after 2 of 4 beats on sel=1.
  - in_ready drops the same cycle and no further dvalid=8'h02 strobes occur.
  - Next burst goes to sel=2.
  - Also: chan_en=0 leads to IDLE with busy=0.
- Async reset mid-burst: pull rst_n low during XFER on sel=5.
  - dvalid=0, sel=0, busy=0 immediately.
  - After release, the first burst goes to sel=0.
